// File: rtl/atm_pin_entry_if.sv
// Keypad / card-reader side of the PIN collector: key strobes and stored PIN in,
// verification result and attempt/lock status out.
interface atm_pin_entry_if #(
    parameter int unsigned PIN_DIGITS = 4,
    parameter int unsigned MAX_TRIES  = 3
);
    localparam int unsigned PIN_W = 4 * PIN_DIGITS;
    localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned ATT_W = $clog2(MAX_TRIES + 1);

    logic             start;
    logic             new_card;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [PIN_W-1:0] stored_pin;
    logic             done;
    logic             pin_check;
    logic             timeout;
    logic             locked;
    logic [CNT_W-1:0] digit_count;
    logic [ATT_W-1:0] attempts_left;

    modport master (
        output start, new_card, key_valid, key_code, stored_pin,
        input  done, pin_check, timeout, locked, digit_count, attempts_left
    );

    modport slave (
        input  start, new_card, key_valid, key_code, stored_pin,
        output done, pin_check, timeout, locked, digit_count, attempts_left
    );
endinterface

// File: rtl/atm_pin_entry.sv
// Collects keypad digits, verifies them against the card PIN, tracks wrong
// attempts with card lock, and abandons an entry after keypad inactivity.
module atm_pin_entry #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic           clk,
    input logic           reset,
    atm_pin_entry_if.slave bus
);
    localparam int unsigned PIN_W   = 4 * PIN_DIGITS;
    localparam int unsigned CNT_W   = $clog2(PIN_DIGITS + 1);
    localparam int unsigned ATT_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(PIN_DIGITS);
    localparam logic [ATT_W-1:0]   ATT_MAX   = ATT_W'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t             state, state_n;
    logic [PIN_W-1:0]   pin_buf, pin_buf_n;
    logic [CNT_W-1:0]   digit_count, digit_count_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [ATT_W-1:0]   attempts_left, attempts_left_n;
    logic               done, done_n;
    logic               pin_check, pin_check_n;
    logic               timeout, timeout_n;
    logic               locked, locked_n;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pin_buf       <= '0;
            digit_count   <= '0;
            timer         <= '0;
            attempts_left <= ATT_MAX;
            done          <= 1'b0;
            pin_check     <= 1'b0;
            timeout       <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state         <= state_n;
            pin_buf       <= pin_buf_n;
            digit_count   <= digit_count_n;
            timer         <= timer_n;
            attempts_left <= attempts_left_n;
            done          <= done_n;
            pin_check     <= pin_check_n;
            timeout       <= timeout_n;
            locked        <= locked_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n         = state;
        pin_buf_n       = pin_buf;
        digit_count_n   = digit_count;
        timer_n         = timer;
        attempts_left_n = attempts_left;
        done_n          = 1'b0;
        pin_check_n     = pin_check;
        timeout_n       = timeout;
        locked_n        = locked;

        if (bus.new_card) begin
            // A fresh card aborts any open entry silently and restores the budget
            state_n         = S_IDLE;
            pin_buf_n       = '0;
            digit_count_n   = '0;
            timer_n         = '0;
            attempts_left_n = ATT_MAX;
            locked_n        = 1'b0;
            pin_check_n     = 1'b0;
            timeout_n       = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pin_check_n = 1'b0;
                        timeout_n   = 1'b0;
                        if (locked) begin
                            done_n = 1'b1;
                        end else begin
                            state_n       = S_COLLECT;
                            pin_buf_n     = '0;
                            digit_count_n = '0;
                            timer_n       = '0;
                        end
                    end
                end

                S_COLLECT: begin
                    if (bus.start) begin
                        pin_buf_n     = '0;
                        digit_count_n = '0;
                        timer_n       = '0;
                    end else if (bus.key_valid) begin
                        timer_n = '0;
                        if (bus.key_code <= 4'h9) begin
                            if (digit_count < CNT_FULL) begin
                                pin_buf_n     = (pin_buf << 4) | PIN_W'(bus.key_code);
                                digit_count_n = digit_count + CNT_W'(1);
                            end
                        end else if (bus.key_code == KEY_CLEAR) begin
                            pin_buf_n     = '0;
                            digit_count_n = '0;
                        end else if (bus.key_code == KEY_ENTER) begin
                            if (digit_count == CNT_FULL) begin
                                state_n = S_CHECK;
                            end
                        end
                    end else if (timer == TIMER_END) begin
                        // Inactivity: close the entry without charging an attempt
                        state_n       = S_IDLE;
                        done_n        = 1'b1;
                        pin_check_n   = 1'b0;
                        timeout_n     = 1'b1;
                        pin_buf_n     = '0;
                        digit_count_n = '0;
                        timer_n       = '0;
                    end else begin
                        timer_n = timer + TIMER_W'(1);
                    end
                end

                S_CHECK: begin
                    state_n       = S_IDLE;
                    done_n        = 1'b1;
                    timeout_n     = 1'b0;
                    pin_buf_n     = '0;
                    digit_count_n = '0;
                    if (pin_buf == bus.stored_pin) begin
                        pin_check_n     = 1'b1;
                        attempts_left_n = ATT_MAX;
                    end else begin
                        pin_check_n = 1'b0;
                        if (attempts_left != '0) begin
                            attempts_left_n = attempts_left - ATT_W'(1);
                        end
                        if (attempts_left <= ATT_W'(1)) begin
                            locked_n = 1'b1;
                        end
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign bus.done          = done;
    assign bus.pin_check     = pin_check;
    assign bus.timeout       = timeout;
    assign bus.locked        = locked;
    assign bus.digit_count   = digit_count;
    assign bus.attempts_left = attempts_left;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry: PIN match/mismatch, lock, CLEAR/ENTER edge
// cases, inactivity timeout, reset mid-entry and new_card priority.
module tb_atm_pin_entry;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    atm_pin_entry_if #(.PIN_DIGITS(4), .MAX_TRIES(3)) bus ();

    atm_pin_entry #(
        .PIN_DIGITS    (4),
        .MAX_TRIES     (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Four digits plus ENTER, then the CHECK cycle: returns in the done cycle
    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) press(p[4*i +: 4]);
        press(4'hB);
        tick();
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.new_card   = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.stored_pin = 16'h1234;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        check("rst_done",     32'(bus.done),          32'(0));
        check("rst_pin",      32'(bus.pin_check),     32'(0));
        check("rst_timeout",  32'(bus.timeout),       32'(0));
        check("rst_locked",   32'(bus.locked),        32'(0));
        check("rst_count",    32'(bus.digit_count),   32'(0));
        check("rst_attempts", 32'(bus.attempts_left), 32'(3));

        // Correct PIN 1234 with exact done latency
        pulse_start();
        check("t1_count0", 32'(bus.digit_count), 32'(0));
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("t1_count4", 32'(bus.digit_count), 32'(4));
        press(4'hB);
        check("t1_done_early", 32'(bus.done), 32'(0));
        tick();
        check("t1_done",     32'(bus.done),          32'(1));
        check("t1_pin",      32'(bus.pin_check),     32'(1));
        check("t1_attempts", 32'(bus.attempts_left), 32'(3));
        check("t1_count_clr",32'(bus.digit_count),   32'(0));
        tick();
        check("t1_done_low", 32'(bus.done),      32'(0));
        check("t1_pin_held", 32'(bus.pin_check), 32'(1));

        // Three wrong entries lock the card
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            enter_pin(16'h1235);
            check("t2_done",     32'(bus.done),          32'(1));
            check("t2_pin",      32'(bus.pin_check),     32'(0));
            check("t2_attempts", 32'(bus.attempts_left), 32'(2 - i));
            check("t2_locked",   32'(bus.locked),        32'(i == 2));
            tick();
        end
        pulse_start();
        check("t2_lock_done", 32'(bus.done),      32'(1));
        check("t2_lock_pin",  32'(bus.pin_check), 32'(0));
        check("t2_lock_to",   32'(bus.timeout),   32'(0));
        tick();
        check("t2_lock_done_low", 32'(bus.done), 32'(0));
        press(4'h1);
        check("t2_lock_no_collect", 32'(bus.digit_count), 32'(0));
        check("t2_att_floor",       32'(bus.attempts_left), 32'(0));
        bus.new_card = 1'b1;
        tick();
        bus.new_card = 1'b0;
        check("t2_nc_attempts", 32'(bus.attempts_left), 32'(3));
        check("t2_nc_locked",   32'(bus.locked),        32'(0));

        // Relock, then new_card and start together
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            enter_pin(16'h0000);
            tick();
        end
        check("t6_relocked", 32'(bus.locked), 32'(1));
        bus.new_card = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.new_card = 1'b0;
        bus.start    = 1'b0;
        check("t6_locked",   32'(bus.locked),        32'(0));
        check("t6_attempts", 32'(bus.attempts_left), 32'(3));
        check("t6_done",     32'(bus.done),          32'(0));
        tick();
        check("t6_done_late", 32'(bus.done), 32'(0));
        press(4'h1);
        check("t6_idle", 32'(bus.digit_count), 32'(0));

        // CLEAR, short ENTER, ignored codes, overflow digit
        bus.stored_pin = 16'h9876;
        pulse_start();
        press(4'h1); press(4'h2);
        check("t3_count2", 32'(bus.digit_count), 32'(2));
        press(4'hA);
        check("t3_clear", 32'(bus.digit_count), 32'(0));
        press(4'h9);
        press(4'hB);
        tick();
        check("t3_short_enter", 32'(bus.done),        32'(0));
        check("t3_count1",      32'(bus.digit_count), 32'(1));
        press(4'hC);
        check("t3_ignored_code", 32'(bus.digit_count), 32'(1));
        press(4'h8); press(4'h7); press(4'h6);
        check("t3_count4", 32'(bus.digit_count), 32'(4));
        press(4'h5);
        check("t3_overflow", 32'(bus.digit_count), 32'(4));
        press(4'hB);
        tick();
        check("t3_done", 32'(bus.done),      32'(1));
        check("t3_pin",  32'(bus.pin_check), 32'(1));

        // Inactivity timeout after one digit
        pulse_start();
        check("t4_pin_clr", 32'(bus.pin_check), 32'(0));
        press(4'h1);
        repeat (15) tick();
        check("t4_not_yet", 32'(bus.done),        32'(0));
        check("t4_count",   32'(bus.digit_count), 32'(1));
        tick();
        check("t4_done",     32'(bus.done),          32'(1));
        check("t4_timeout",  32'(bus.timeout),       32'(1));
        check("t4_pin",      32'(bus.pin_check),     32'(0));
        check("t4_attempts", 32'(bus.attempts_left), 32'(3));
        tick();
        check("t4_done_low", 32'(bus.done),    32'(0));
        check("t4_to_held",  32'(bus.timeout), 32'(1));

        // Reset mid-entry, then a clean passing entry
        pulse_start();
        check("t5_to_clr", 32'(bus.timeout), 32'(0));
        enter_pin(16'h1111);
        check("t5_attempts2", 32'(bus.attempts_left), 32'(2));
        tick();
        pulse_start();
        press(4'h1); press(4'h2);
        check("t5_count2", 32'(bus.digit_count), 32'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_count",    32'(bus.digit_count),   32'(0));
        check("t5_rst_attempts", 32'(bus.attempts_left), 32'(3));
        check("t5_rst_done",     32'(bus.done),          32'(0));
        check("t5_rst_pin",      32'(bus.pin_check),     32'(0));
        check("t5_rst_locked",   32'(bus.locked),        32'(0));
        tick();
        check("t5_no_done", 32'(bus.done), 32'(0));
        pulse_start();
        enter_pin(16'h9876);
        check("t5_pass_done", 32'(bus.done),      32'(1));
        check("t5_pass_pin",  32'(bus.pin_check), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

Keypad PIN collector and verifier that sits directly upstream of the ATM control FSM. It gathers PIN digits from the keypad, compares them against the card's stored PIN, and delivers a `done` pulse with a `pin_check` result that the control FSM samples in its PIN-verify step. It also tracks wrong attempts, locks the card after `MAX_TRIES` failures, and abandons entry on keypad inactivity.

## Interface
- `PIN_DIGITS`, 4, number of digits in a PIN (1..8).
- `MAX_TRIES`, 3, wrong entries allowed before lock (≥1).
- `TIMEOUT_CYCLES`, 1000, idle cycles in COLLECT before entry is abandoned (≥2).

- `clk`  in  1  single clock, rising edge; one clock only.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse: begin a PIN entry.
- `new_card`  in  1  pulse: new card seated; reloads the attempt budget and clears lock.
- `key_valid`  in  1  keypad strobe, one cycle per key press.
- `key_code`  in  4  0x0–0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF ignored.
- `stored_pin`  in  4*PIN_DIGITS  BCD PIN from the card; first digit is in the MSBs; stable while an entry is open.
- `done`  out  1  one-cycle pulse: result available.
- `pin_check`  out  1  1 = PIN matched; valid from `done`, held until the next accepted `start`.
- `timeout`  out  1  1 = the last entry was abandoned for inactivity; held like `pin_check`.
- `locked`  out  1  card locked.
- `digit_count`  out  clog2(PIN_DIGITS+1)  digits currently buffered (for display masking).
- `attempts_left`  out  clog2(MAX_TRIES+1)  remaining tries.

## Operation
- States: IDLE, COLLECT, CHECK. All outputs are registered.
- Reset values: state IDLE; `done`=0, `pin_check`=0, `timeout`=0, `locked`=0, `digit_count`=0, `attempts_left`=MAX_TRIES; buffer and timer 0.
- `new_card` in any state:
  - reloads `attempts_left`=MAX_TRIES and clears `locked`;
  - sends the state to IDLE (aborts an open entry without `done`);
  - clears `pin_check` and `timeout`;
  - takes priority over `start` in the same cycle.
- IDLE:
  - keys are ignored;
  - `start` with `locked`=0: go to COLLECT, clear buffer, `digit_count`=0, timer=0, clear `pin_check` and `timeout`;
  - `start` with `locked`=1: stay in IDLE and emit `done` with `pin_check`=0 and `timeout`=0.
- COLLECT, on `key_valid`:
  - Digit with `digit_count`<PIN_DIGITS: shift the digit into the buffer LSBs, increment the count.
  - Digit with the buffer full: ignored.
  - CLEAR: buffer=0, `digit_count`=0.
  - ENTER with `digit_count`==PIN_DIGITS: go to CHECK.
  - ENTER with a short buffer: ignored.
  - Codes 0xC–0xF: ignored.
  - Every `key_valid`, including ignored codes, resets the timer.
- COLLECT, other events:
  - `start` re-arms the entry: clear buffer and timer.
  - Timer reaching TIMEOUT_CYCLES-1 with no key: emit `done`, `pin_check`=0, `timeout`=1, go to IDLE; `attempts_left` is unchanged.
- CHECK (one cycle), comparing buffer against `stored_pin`:
  - Match: `pin_check`=1, `attempts_left`=MAX_TRIES.
  - Mismatch: `pin_check`=0, decrement `attempts_left`; on reaching 0, set `locked`=1.
  - In both cases emit `done`, clear buffer and `digit_count`, go to IDLE.
- `attempts_left` never wraps below 0.
- `locked` clears only on `new_card` or `reset`.

## Timing
- ENTER accepted at edge N: CHECK during cycle N+1; `done`/`pin_check` high in cycle N+2; `done` low in N+3.
- Locked `start` at edge N: `done` high in cycle N+1.
- Timeout: `done` and `timeout` high one cycle after the TIMEOUT_CYCLES-th consecutive keyless cycle in COLLECT.
- A key accepted at edge N is reflected in `digit_count` in cycle N+1.
- `start` in CHECK is ignored; it must be re-issued after `done`.
- `reset` mid-entry returns everything to reset values at the next edge; no `done` is emitted.

## Test plan
- PIN 1234, `start`, keys 1,2,3,4,ENTER: `done` two cycles after ENTER; `pin_check`=1, `attempts_left`=3, `digit_count` 0→4→0.
- Stored 1234, three entries of 1235: `attempts_left` 2,1,0; `locked`=1 after the third `done`. A fourth `start` gives `done` next cycle with `pin_check`=0. `new_card` restores `attempts_left`=3 and `locked`=0.
- Keys 1,2,CLEAR,9,ENTER,8,7,6,5,ENTER then stored 9876: the early ENTER is ignored, the 5th digit is ignored, and `pin_check`=1.
- `start`, key 1, then no keys for TIMEOUT_CYCLES (bench parameter 16): `done` with `timeout`=1, `pin_check`=0, `attempts_left` unchanged.
- `reset` asserted after 2 digits: the next cycle shows all reset values, and a later `start` plus a full correct entry passes.
- `new_card` and `start` in the same cycle while locked: lock clears, state stays IDLE, no `done`.
